// File: rtl/bip_debug_unit.sv
`default_nettype none
// ============================================================================
// Module      : bip_debug_unit
// Description : Counts BIPI run cycles, then snapshots PC/ACC/count on Halt and
//               streams it as a 9-byte checksummed frame over a byte handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module bip_debug_unit #(
    parameter int         PC_W   = 11,
    parameter int         ACC_W  = 16,
    parameter int         CNT_W  = 24,
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Halt,
    input  logic [PC_W-1:0]  Pc,
    input  logic [ACC_W-1:0] Acc,
    output logic [7:0]       TxData,
    output logic             TxValid,
    input  logic             TxReady,
    output logic             Done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        pc_q, pc_d;
    logic [15:0]        acc_q, acc_d;
    logic [23:0]        snap_cnt_q, snap_cnt_d;
    logic [3:0]         idx_q, idx_d;
    logic [7:0]         chk_q, chk_d;

    logic [15:0]        pc_ext;
    logic [15:0]        acc_ext;
    logic [23:0]        cnt_ext;
    logic [7:0]         frame_byte;
    logic               xfer;

    always_comb begin
        pc_ext  = 16'(Pc);
        acc_ext = 16'(Acc);
        cnt_ext = 24'(cnt_q);
    end

    // Byte currently on offer, selected from the frozen snapshot.
    always_comb begin
        frame_byte = chk_q;
        case (idx_q)
            4'd0:    frame_byte = HEADER;
            4'd1:    frame_byte = pc_q[15:8];
            4'd2:    frame_byte = pc_q[7:0];
            4'd3:    frame_byte = acc_q[15:8];
            4'd4:    frame_byte = acc_q[7:0];
            4'd5:    frame_byte = snap_cnt_q[23:16];
            4'd6:    frame_byte = snap_cnt_q[15:8];
            4'd7:    frame_byte = snap_cnt_q[7:0];
            default: frame_byte = chk_q;
        endcase
    end

    always_comb begin
        TxValid = (state_q == ST_SEND);
        TxData  = TxValid ? frame_byte : 8'h00;
        Done    = (state_q == ST_DONE);
        xfer    = TxValid & TxReady;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        acc_d      = acc_q;
        snap_cnt_d = snap_cnt_q;
        idx_d      = idx_q;
        chk_d      = chk_q;

        case (state_q)
            ST_IDLE: begin
                if (Halt) begin
                    pc_d       = pc_ext;
                    acc_d      = acc_ext;
                    snap_cnt_d = cnt_ext;
                    idx_d      = 4'd0;
                    chk_d      = 8'h00;
                    state_d    = ST_SEND;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    if ((idx_q >= 4'd1) && (idx_q <= 4'd7)) begin
                        chk_d = chk_q ^ frame_byte;
                    end
                    if (idx_q == 4'd8) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                if (!Halt) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pc_q       <= 16'h0000;
            acc_q      <= 16'h0000;
            snap_cnt_q <= 24'h000000;
            idx_q      <= 4'd0;
            chk_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            acc_q      <= acc_d;
            snap_cnt_q <= snap_cnt_d;
            idx_q      <= idx_d;
            chk_q      <= chk_d;
        end
    end

endmodule
`default_nettype wire
